// File: rtl/markov_sequence_generator_pkg.sv
// Shared widths, state encoding and LFSR constants for the Markov generator and its learner.
// The widths match the learner's transition-list layout {prev_sym, next_sym, count}.
package markov_sequence_generator_pkg;

    localparam int SYM_W  = 8;
    localparam int CNT_W  = 8;
    localparam int ADDR_W = 6;
    localparam int LEN_W  = 8;
    localparam int IDX_W  = ADDR_W + 1;
    localparam int TOT_W  = ADDR_W + CNT_W + 1;
    localparam int LFSR_W = 16;
    localparam int PROD_W = LFSR_W + TOT_W;

    localparam logic [LFSR_W-1:0] LFSR_DEFAULT = 16'hACE1;
    // Right-shift Galois form of x^16 + x^14 + x^13 + x^11
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;

    typedef enum logic [2:0] {
        GEN_IDLE   = 3'd0,
        GEN_SUM    = 3'd1,
        GEN_DRAW   = 3'd2,
        GEN_SELECT = 3'd3,
        GEN_EMIT   = 3'd4,
        GEN_FINISH = 3'd5
    } gen_state_t;

    typedef struct packed {
        logic [SYM_W-1:0] prev;
        logic [SYM_W-1:0] next;
        logic [CNT_W-1:0] count;
    } tbl_entry_t;

    function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/markov_sequence_generator_if.sv
// Control, transition-list read port and symbol stream of the generator.
// master = generator side, slave = the environment (host, list RAM, downstream sink).
interface markov_sequence_generator_if;
    import markov_sequence_generator_pkg::*;

    logic              start;
    logic [SYM_W-1:0]  seed_sym;
    logic [LEN_W-1:0]  out_len;
    logic [IDX_W-1:0]  tbl_len;
    logic [LFSR_W-1:0] lfsr_seed;
    logic              busy;
    logic              done;
    logic              dead_end;

    logic [ADDR_W-1:0] tbl_addr;
    logic [SYM_W-1:0]  tbl_prev;
    logic [SYM_W-1:0]  tbl_next;
    logic [CNT_W-1:0]  tbl_count;

    logic [SYM_W-1:0]  sym_out;
    logic              sym_valid;
    logic              sym_ready;

    modport master (
        input  start, seed_sym, out_len, tbl_len, lfsr_seed,
        input  tbl_prev, tbl_next, tbl_count, sym_ready,
        output busy, done, dead_end, tbl_addr, sym_out, sym_valid
    );

    modport slave (
        output start, seed_sym, out_len, tbl_len, lfsr_seed,
        output tbl_prev, tbl_next, tbl_count, sym_ready,
        input  busy, done, dead_end, tbl_addr, sym_out, sym_valid
    );

endinterface

// File: rtl/markov_sequence_generator_lfsr.sv
// 16-bit Galois LFSR: load (zero seed replaced by default) has priority over step.
// o_step_val is the value the register takes on the next step, available combinationally.
module markov_sequence_generator_lfsr
    import markov_sequence_generator_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_step,
    output logic [LFSR_W-1:0] o_step_val
);

    logic [LFSR_W-1:0] r_lfsr;

    assign o_step_val = lfsr_advance(r_lfsr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_DEFAULT;
        end else if (i_load) begin
            r_lfsr <= (i_seed == '0) ? LFSR_DEFAULT : i_seed;
        end else if (i_step) begin
            r_lfsr <= o_step_val;
        end
    end

endmodule

// File: rtl/markov_sequence_generator.sv
// Walks the learned transition list to emit a count-weighted random symbol sequence.
// Per symbol: (tbl_len+1) sum + 1 draw + (hit+2) select + emit; sym_valid holds until sym_ready.
module markov_sequence_generator
    import markov_sequence_generator_pkg::*;
(
    input  logic clk,
    input  logic reset,
    markov_sequence_generator_if.master bus
);

    gen_state_t        r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_idx, r_tbl_len;
    logic [SYM_W-1:0]  r_cur, r_next;
    logic [LEN_W-1:0]  r_out_len, r_emitted;
    logic [TOT_W-1:0]  r_total, r_run, r_draw;
    logic              r_dead_end;

    logic [LFSR_W-1:0] w_lfsr_step;
    logic              w_match, w_hit, w_scan_end, w_last_sym, w_zero_run;
    logic [TOT_W-1:0]  w_add, w_total_nxt, w_run_nxt, w_draw;
    logic              w_busy, w_done, w_sym_vld;

    markov_sequence_generator_lfsr u_lfsr (
        .clk        (clk),
        .rst        (reset),
        .i_load     ((r_state == GEN_IDLE) && bus.start),
        .i_seed     (bus.lfsr_seed),
        .i_step     (r_state == GEN_DRAW),
        .o_step_val (w_lfsr_step)
    );

    // Read data lags the address by one cycle, so index 0 carries no data yet.
    assign w_match     = (r_idx != '0) && (bus.tbl_prev == r_cur);
    assign w_add       = w_match ? TOT_W'(bus.tbl_count) : '0;
    assign w_total_nxt = r_total + w_add;
    assign w_run_nxt   = r_run + w_add;
    assign w_hit       = w_match && (w_run_nxt > r_draw);
    assign w_scan_end  = (r_idx == r_tbl_len);
    assign w_last_sym  = ((r_emitted + LEN_W'(1)) == r_out_len);
    assign w_zero_run  = (bus.out_len == '0) || (bus.tbl_len == '0);
    assign w_draw      = TOT_W'((PROD_W'(w_lfsr_step) * PROD_W'(r_total)) >> LFSR_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= GEN_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_sym_vld   = 1'b0;
        case (r_state)
            GEN_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = w_zero_run ? GEN_FINISH : GEN_SUM;
                end
            end
            GEN_SUM: begin
                w_busy = 1'b1;
                if (w_scan_end) begin
                    w_state_nxt = (w_total_nxt == '0) ? GEN_FINISH : GEN_DRAW;
                end
            end
            GEN_DRAW: begin
                w_busy      = 1'b1;
                w_state_nxt = GEN_SELECT;
            end
            GEN_SELECT: begin
                w_busy = 1'b1;
                if (w_hit) begin
                    w_state_nxt = GEN_EMIT;
                end else if (w_scan_end) begin
                    w_state_nxt = GEN_FINISH;
                end
            end
            GEN_EMIT: begin
                w_busy    = 1'b1;
                w_sym_vld = 1'b1;
                if (bus.sym_ready) begin
                    w_state_nxt = w_last_sym ? GEN_FINISH : GEN_SUM;
                end
            end
            GEN_FINISH: begin
                w_done      = 1'b1;
                w_state_nxt = GEN_IDLE;
            end
            default: w_state_nxt = GEN_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx      <= '0;
            r_tbl_len  <= '0;
            r_cur      <= '0;
            r_next     <= '0;
            r_out_len  <= '0;
            r_emitted  <= '0;
            r_total    <= '0;
            r_run      <= '0;
            r_draw     <= '0;
            r_dead_end <= 1'b0;
        end else begin
            case (r_state)
                GEN_IDLE: begin
                    if (bus.start) begin
                        r_cur      <= bus.seed_sym;
                        r_out_len  <= bus.out_len;
                        r_tbl_len  <= bus.tbl_len;
                        r_emitted  <= '0;
                        r_total    <= '0;
                        r_idx      <= '0;
                        r_dead_end <= (bus.tbl_len == '0) && (bus.out_len != '0);
                    end
                end
                GEN_SUM: begin
                    r_total <= w_total_nxt;
                    r_idx   <= w_scan_end ? '0 : r_idx + IDX_W'(1);
                    if (w_scan_end && (w_total_nxt == '0)) begin
                        r_dead_end <= 1'b1;
                    end
                end
                GEN_DRAW: begin
                    r_draw <= w_draw;
                    r_run  <= '0;
                    r_idx  <= '0;
                end
                GEN_SELECT: begin
                    r_run <= w_run_nxt;
                    if (w_hit) begin
                        r_next <= bus.tbl_next;
                        r_idx  <= '0;
                    end else if (w_scan_end) begin
                        // Only reachable if the list changed under us mid-run
                        r_idx      <= '0;
                        r_dead_end <= 1'b1;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                GEN_EMIT: begin
                    if (bus.sym_ready) begin
                        r_cur     <= r_next;
                        r_emitted <= r_emitted + LEN_W'(1);
                        r_total   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.dead_end  = r_dead_end;
    assign bus.tbl_addr  = r_idx[ADDR_W-1:0];
    assign bus.sym_valid = w_sym_vld;
    assign bus.sym_out   = w_sym_vld ? r_next : '0;

endmodule

// File: tb/tb_markov_sequence_generator.sv
// Randomized scoreboard bench: a list-walking reference model predicts every symbol,
// run length, dead_end and idle latency; a negedge monitor checks the stream as it appears.
module tb_markov_sequence_generator;
    import markov_sequence_generator_pkg::*;

    localparam logic [7:0] SYM_A = 8'h41;
    localparam logic [7:0] SYM_B = 8'h42;
    localparam logic [7:0] SYM_C = 8'h43;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    markov_sequence_generator_if bus ();
    markov_sequence_generator dut (.clk(clk), .reset(reset), .bus(bus));

    tbl_entry_t mem [0:63];
    always @(posedge clk) begin
        bus.tbl_prev  <= mem[bus.tbl_addr].prev;
        bus.tbl_next  <= mem[bus.tbl_addr].next;
        bus.tbl_count <= mem[bus.tbl_addr].count;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int hs_count = 0;
    int a_count  = 0;
    int done_count = 0;
    int bp_mode  = 0;
    logic [7:0] exp_q [$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endfunction

    function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
        logic [15:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    // Reference: plain arithmetic over the first tlen list entries
    task automatic model_run(input logic [7:0] seed, input int olen, input int tlen,
                             input logic [15:0] lseed, output int n_exp, output bit dead,
                             output int cyc);
        logic [15:0] l;
        logic [7:0]  cur;
        longint      total, r, acc;
        int          h;
        l = (lseed == 16'h0) ? 16'hACE1 : lseed;
        cur = seed;
        n_exp = 0; dead = 1'b0; cyc = 0;
        if (olen != 0 && tlen == 0) dead = 1'b1;
        if (olen != 0 && tlen != 0) begin
            for (int i = 0; i < olen; i++) begin
                total = 0;
                for (int e = 0; e < tlen; e++)
                    if (mem[e].prev == cur) total += longint'(mem[e].count);
                cyc += tlen + 1;
                if (total == 0) begin
                    dead = 1'b1;
                    break;
                end
                l = ref_lfsr(l);
                r = (longint'(l) * total) >>> 16;
                acc = 0; h = 0;
                for (int e = 0; e < tlen; e++) begin
                    if (mem[e].prev == cur) begin
                        acc += longint'(mem[e].count);
                        if (acc > r) begin
                            h = e;
                            break;
                        end
                    end
                end
                cyc += 1 + (h + 2) + 1;
                cur = mem[h].next;
                exp_q.push_back(cur);
                n_exp++;
            end
        end
    endtask

    initial begin
        logic       prev_stall;
        logic [7:0] prev_sym;
        prev_stall = 1'b0;
        prev_sym   = 8'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 32'(bus.sym_valid), 32'd1);
                    chk("hold_sym", 32'(bus.sym_out), 32'(prev_sym));
                end
                if (bus.sym_valid && bus.sym_ready) begin
                    hs_count++;
                    if (bus.sym_out == SYM_A) a_count++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL sym_extra: got 0x%0h, expected no symbol", bus.sym_out);
                    end else begin
                        chk("sym", 32'(bus.sym_out), 32'(exp_q.pop_front()));
                    end
                end
                prev_stall = bus.sym_valid && !bus.sym_ready;
                prev_sym   = bus.sym_out;
                if (bus.done) done_count++;
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0: bus.sym_ready = 1'b1;
                1: bus.sym_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (bus.sym_valid) begin
                        if (cnt >= 10) begin
                            bus.sym_ready = 1'b1;
                            cnt = 0;
                        end else begin
                            bus.sym_ready = 1'b0;
                            cnt++;
                        end
                    end else begin
                        bus.sym_ready = 1'b0;
                        cnt = 0;
                    end
                end
            endcase
        end
    end

    task automatic fill_junk();
        for (int i = 0; i < 64; i++) begin
            mem[i].prev  = 8'($urandom_range(0, 3));
            mem[i].next  = 8'($urandom_range(0, 3));
            mem[i].count = 8'($urandom_range(1, 255));
        end
    endtask

    task automatic set_entry(input int i, input logic [7:0] p, input logic [7:0] n, input logic [7:0] c);
        mem[i].prev = p; mem[i].next = n; mem[i].count = c;
    endtask

    task automatic pulse_start(input logic [7:0] seed, input int olen, input int tlen, input logic [15:0] lseed);
        @(posedge clk);
        #1;
        bus.seed_sym  = seed;
        bus.out_len   = 8'(olen);
        bus.tbl_len   = 7'(tlen);
        bus.lfsr_seed = lseed;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run(input logic [7:0] seed, input int olen, input int tlen,
                       input logic [15:0] lseed, input int mode, input string tag);
        int n_exp, cyc_exp, cyc;
        bit dead_exp, seen;
        exp_q.delete();
        model_run(seed, olen, tlen, lseed, n_exp, dead_exp, cyc_exp);
        hs_count = 0;
        bp_mode  = mode;
        pulse_start(seed, olen, tlen, lseed);
        seen = 1'b0; cyc = 0;
        for (int c = 1; c <= 20000 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) chk({tag, "_busy"}, 32'(bus.busy), 32'(olen != 0 && tlen != 0));
            if (bus.done) begin
                seen = 1'b1;
                cyc = c;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_dead_end"}, 32'(bus.dead_end), 32'(dead_exp));
            chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
            chk({tag, "_sym_count"}, 32'(hs_count), 32'(n_exp));
            chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
            if (mode == 0) chk({tag, "_latency"}, 32'(cyc), 32'(cyc_exp + 1));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int tot, d0, tl, ol;
        bus.start = 1'b0; bus.seed_sym = '0; bus.out_len = '0; bus.tbl_len = '0;
        bus.lfsr_seed = '0; bus.sym_ready = 1'b0;
        fill_junk();
        #3;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_valid", 32'(bus.sym_valid), 32'd0);
        chk("rst_sym", 32'(bus.sym_out), 32'd0);
        chk("rst_addr", 32'(bus.tbl_addr), 32'd0);
        chk("rst_dead", 32'(bus.dead_end), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        fill_junk();
        set_entry(0, SYM_A, SYM_B, 8'd5);
        set_entry(1, SYM_B, SYM_C, 8'd3);
        set_entry(2, SYM_C, SYM_A, 8'd1);
        run(SYM_A, 6, 3, 16'h1234, 0, "chain");
        run(SYM_A, 6, 3, 16'h1234, 2, "chain_bp");

        fill_junk();
        set_entry(0, SYM_A, SYM_B, 8'd2);
        run(SYM_A, 5, 1, 16'h0042, 0, "deadend");
        run(SYM_A, 0, 1, 16'h0042, 0, "zero_len");
        run(SYM_A, 3, 0, 16'h0042, 0, "zero_tbl");

        fill_junk();
        set_entry(0, SYM_A, SYM_A, 8'd3);
        set_entry(1, SYM_A, SYM_B, 8'd1);
        set_entry(2, SYM_B, SYM_A, 8'd3);
        set_entry(3, SYM_B, SYM_B, 8'd1);
        run(SYM_A, 20, 4, 16'h0000, 0, "seed0");
        a_count = 0; tot = 0;
        for (int i = 0; i < 16; i++) begin
            run(SYM_A, 250, 4, 16'(i * 40503 + 1), 0, "weight");
            tot += hs_count;
        end
        $display("weighting: %0d of %0d symbols were A", a_count, tot);
        chk("weight_frac_in_range", 32'((a_count * 100 >= 70 * tot) && (a_count * 100 <= 80 * tot)), 32'd1);

        for (int k = 0; k < 8; k++) begin
            fill_junk();
            tl = int'($urandom_range(1, 12));
            ol = int'($urandom_range(1, 20));
            for (int e = 0; e < tl; e++)
                set_entry(e, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 7)));
            run(8'($urandom_range(0, 3)), ol, tl, 16'($urandom), int'($urandom_range(0, 2)), "rand");
        end

        for (int e = 0; e < 64; e++)
            set_entry(e, 8'($urandom_range(0, 1)), 8'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        set_entry(63, 8'd0, 8'd1, 8'd255);
        run(8'd0, 8, 64, 16'hBEEF, 1, "full_tbl");

        fill_junk();
        set_entry(0, SYM_A, SYM_B, 8'd5);
        set_entry(1, SYM_B, SYM_C, 8'd3);
        set_entry(2, SYM_C, SYM_A, 8'd1);
        exp_q.delete();
        bp_mode = 0;
        pulse_start(SYM_A, 6, 3, 16'h1234);
        repeat (6) @(negedge clk);
        d0 = done_count;
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_valid", 32'(bus.sym_valid), 32'd0);
        chk("mid_rst_sym", 32'(bus.sym_out), 32'd0);
        chk("mid_rst_addr", 32'(bus.tbl_addr), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_rst_no_done", 32'(done_count), 32'(d0));
        run(SYM_A, 6, 3, 16'h1234, 0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
